// File: rtl/dffrsnq_seq_pkg.sv
// Shared types and default timing constants for the dffrsnq set/reset sequencer.
package dffrsnq_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2
  } op_e;

  localparam int unsigned DEF_PULSE_CYC = 2;
  localparam int unsigned DEF_RECOV_CYC = 2;
  localparam int unsigned DEF_CNT_W     = 4;

endpackage

// File: rtl/dffrsnq_seq_timer.sv
// Loadable down-counter with zero flag; stops at zero rather than wrapping.
module dffrsnq_seq_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dffrsnq_async_ctrl_seq.sv
// Sequencer driving SETN/RN of an async set/reset flop bank: registered
// active-low pulses of PULSE_CYC cycles, then a RECOV_CYC recovery window
// before CLK_EN returns high. SETN and RN are never low together.
// Optional macro DFFRSNQ_SEQ_QUEUE_EN adds a one-deep pending-request slot;
// without it any strobe while busy is dropped.
module dffrsnq_async_ctrl_seq
  import dffrsnq_seq_pkg::*;
#(
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned RECOV_CYC = DEF_RECOV_CYC,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic SET_REQ,
  input  logic CLR_REQ,
  output logic SETN,
  output logic RN,
  output logic CLK_EN,
  output logic BUSY,
  output logic REQ_ACK,
  output logic DONE,
  output logic DROP
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
`ifdef DFFRSNQ_SEQ_QUEUE_EN
  op_e              pend_q, pend_d;
`endif

  logic             setn_q, setn_d;
  logic             rn_q, rn_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  dffrsnq_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  // Next-state, timer control and next registered output values.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    drop_d   = 1'b0;
`ifdef DFFRSNQ_SEQ_QUEUE_EN
    pend_d   = pend_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (CLR_REQ || SET_REQ) begin
          state_d  = ST_ASSERT;
          op_d     = CLR_REQ ? OP_CLR : OP_SET;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          ack_d    = 1'b1;
          drop_d   = CLR_REQ && SET_REQ;
        end
      end
      ST_ASSERT: begin
        if (tmr_zero) begin
          state_d  = ST_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = RECOV_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (tmr_zero) begin
          done_d = 1'b1;
`ifdef DFFRSNQ_SEQ_QUEUE_EN
          if (pend_q != OP_NONE) begin
            state_d  = ST_ASSERT;
            op_d     = pend_q;
            pend_d   = OP_NONE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
          end else begin
            state_d = ST_IDLE;
            op_d    = OP_NONE;
          end
`else
          state_d = ST_IDLE;
          op_d    = OP_NONE;
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        op_d    = OP_NONE;
      end
    endcase

    // Strobes arriving while busy; the slot check uses pend_d so a slot
    // emptied by a launch on this same edge can take the new request.
    if ((state_q != ST_IDLE) && (CLR_REQ || SET_REQ)) begin
`ifdef DFFRSNQ_SEQ_QUEUE_EN
      if (pend_d == OP_NONE) begin
        pend_d = CLR_REQ ? OP_CLR : OP_SET;
        ack_d  = 1'b1;
        drop_d = CLR_REQ && SET_REQ;
      end else if (CLR_REQ && (pend_d == OP_SET)) begin
        pend_d = OP_CLR;
        drop_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
`else
      drop_d = 1'b1;
`endif
    end

    setn_d   = !((state_d == ST_ASSERT) && (op_d == OP_SET));
    rn_d     = !((state_d == ST_ASSERT) && (op_d == OP_CLR));
    clk_en_d = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases both pins at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      setn_q   <= 1'b1;
      rn_q     <= 1'b1;
      clk_en_q <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      setn_q   <= setn_d;
      rn_q     <= rn_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

`ifdef DFFRSNQ_SEQ_QUEUE_EN
  // Pending-request slot register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q <= OP_NONE;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  assign SETN    = setn_q;
  assign RN      = rn_q;
  assign CLK_EN  = clk_en_q;
  assign BUSY    = busy_q;
  assign REQ_ACK = ack_q;
  assign DONE    = done_q;
  assign DROP    = drop_q;

endmodule

// File: tb/tb_dffrsnq_async_ctrl_seq.sv
// Directed bench for dffrsnq_async_ctrl_seq. Instance a uses default timing
// (2/2), instance b uses PULSE_CYC=1, RECOV_CYC=15. Expected output vectors
// are {SETN,RN,CLK_EN,BUSY,REQ_ACK,DONE,DROP}, one per clock after the edge
// that samples the matching {RST,CLR_REQ,SET_REQ} stimulus.
module tb_dffrsnq_async_ctrl_seq;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SET_REQ = 1'b0;
  logic CLR_REQ = 1'b0;

  logic SETN_a, RN_a, CLK_EN_a, BUSY_a, REQ_ACK_a, DONE_a, DROP_a;
  logic SETN_b, RN_b, CLK_EN_b, BUSY_b, REQ_ACK_b, DONE_b, DROP_b;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] IDLE_V = 7'b1110000;

  dffrsnq_async_ctrl_seq #(.PULSE_CYC(2), .RECOV_CYC(2), .CNT_W(4)) dut_a (
    .CLK(CLK), .RST(RST), .SET_REQ(SET_REQ), .CLR_REQ(CLR_REQ),
    .SETN(SETN_a), .RN(RN_a), .CLK_EN(CLK_EN_a), .BUSY(BUSY_a),
    .REQ_ACK(REQ_ACK_a), .DONE(DONE_a), .DROP(DROP_a)
  );

  dffrsnq_async_ctrl_seq #(.PULSE_CYC(1), .RECOV_CYC(15), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .SET_REQ(SET_REQ), .CLR_REQ(CLR_REQ),
    .SETN(SETN_b), .RN(RN_b), .CLK_EN(CLK_EN_b), .BUSY(BUSY_b),
    .REQ_ACK(REQ_ACK_b), .DONE(DONE_b), .DROP(DROP_b)
  );

  logic [6:0] obs_a, obs_b;
  assign obs_a = {SETN_a, RN_a, CLK_EN_a, BUSY_a, REQ_ACK_a, DONE_a, DROP_a};
  assign obs_b = {SETN_b, RN_b, CLK_EN_b, BUSY_b, REQ_ACK_b, DONE_b, DROP_b};

  always #5 CLK = ~CLK;

  // Pins must never be low together on either instance.
  always @(negedge CLK) begin
    if ((!SETN_a && !RN_a) || (!SETN_b && !RN_b)) begin
      n_checks++;
      n_fail++;
      $display("FAIL pins_exclusive: SETN_a=%b RN_a=%b SETN_b=%b RN_b=%b required not both 0",
               SETN_a, RN_a, SETN_b, RN_b);
    end
  end

  task automatic do_reset();
    {RST, CLR_REQ, SET_REQ} = 3'b100;
    @(posedge CLK); #1;
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  task automatic test_reset();
    // RST together with a strobe: reset wins
    {RST, CLR_REQ, SET_REQ} = 3'b111;
    @(posedge CLK); #1;
    n_checks++;
    if (obs_a !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_a: got %b want %b", obs_a, IDLE_V);
    end
    n_checks++;
    if (obs_b !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_b: got %b want %b", obs_b, IDLE_V);
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
    @(posedge CLK); #1;
    n_checks++;
    if (obs_a !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want %b", obs_a, IDLE_V);
    end
  endtask

  task automatic test_set();
    logic [2:0] st [6] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [6:0] ex [6] = '{7'b0101100, 7'b0101000, 7'b1101000,
                           7'b1101000, 7'b1110010, 7'b1110000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {RST, CLR_REQ, SET_REQ} = st[i];
      @(posedge CLK); #1;
      n_checks++;
      if (obs_a !== ex[i]) begin
        n_fail++;
        $display("FAIL set[%0d]: got %b want %b", i, obs_a, ex[i]);
      end
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  task automatic test_both();
    logic [2:0] st [6] = '{3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [6:0] ex [6] = '{7'b1001101, 7'b1001000, 7'b1101000,
                           7'b1101000, 7'b1110010, 7'b1110000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {RST, CLR_REQ, SET_REQ} = st[i];
      @(posedge CLK); #1;
      n_checks++;
      if (obs_a !== ex[i]) begin
        n_fail++;
        $display("FAIL both[%0d]: got %b want %b", i, obs_a, ex[i]);
      end
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  task automatic test_clr_then_set();
    logic [2:0] st [10] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`ifdef DFFRSNQ_SEQ_QUEUE_EN
    logic [6:0] ex [10] = '{7'b1001100, 7'b1001000, 7'b1101010, 7'b1101000, 7'b0101010,
                            7'b0101000, 7'b1101000, 7'b1101000, 7'b1110010, 7'b1110000};
`else
    logic [6:0] ex [10] = '{7'b1001100, 7'b1001000, 7'b1101001, 7'b1101000, 7'b1110010,
                            7'b1110000, 7'b1110000, 7'b1110000, 7'b1110000, 7'b1110000};
`endif
    do_reset();
    for (int i = 0; i < 10; i++) begin
      {RST, CLR_REQ, SET_REQ} = st[i];
      @(posedge CLK); #1;
      n_checks++;
      if (obs_a !== ex[i]) begin
        n_fail++;
        $display("FAIL clr_then_set[%0d]: got %b want %b", i, obs_a, ex[i]);
      end
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  task automatic test_three_strobes();
    logic [2:0] st [10] = '{3'b001, 3'b010, 3'b001, 3'b000, 3'b000,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`ifdef DFFRSNQ_SEQ_QUEUE_EN
    logic [6:0] ex [10] = '{7'b0101100, 7'b0101010, 7'b1101001, 7'b1101000, 7'b1001010,
                            7'b1001000, 7'b1101000, 7'b1101000, 7'b1110010, 7'b1110000};
`else
    logic [6:0] ex [10] = '{7'b0101100, 7'b0101001, 7'b1101001, 7'b1101000, 7'b1110010,
                            7'b1110000, 7'b1110000, 7'b1110000, 7'b1110000, 7'b1110000};
`endif
    do_reset();
    for (int i = 0; i < 10; i++) begin
      {RST, CLR_REQ, SET_REQ} = st[i];
      @(posedge CLK); #1;
      n_checks++;
      if (obs_a !== ex[i]) begin
        n_fail++;
        $display("FAIL three_strobes[%0d]: got %b want %b", i, obs_a, ex[i]);
      end
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  task automatic test_rst_mid();
    // CLR, reset during ASSERT, quiet cycles with no DONE, then a fresh SET
    logic [2:0] st [11] = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b000,
                            3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [6:0] ex [11] = '{7'b1001100, 7'b1110000, 7'b1110000, 7'b1110000, 7'b1110000,
                            7'b0101100, 7'b0101000, 7'b1101000, 7'b1101000, 7'b1110010,
                            7'b1110000};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      {RST, CLR_REQ, SET_REQ} = st[i];
      @(posedge CLK); #1;
      n_checks++;
      if (obs_a !== ex[i]) begin
        n_fail++;
        $display("FAIL rst_mid[%0d]: got %b want %b", i, obs_a, ex[i]);
      end
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  task automatic test_back_to_back();
    // second strobe sampled in the DONE cycle of the first
    logic [2:0] st [11] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [6:0] ex [11] = '{7'b0101100, 7'b0101000, 7'b1101000, 7'b1101000, 7'b1110010,
                            7'b1001100, 7'b1001000, 7'b1101000, 7'b1101000, 7'b1110010,
                            7'b1110000};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      {RST, CLR_REQ, SET_REQ} = st[i];
      @(posedge CLK); #1;
      n_checks++;
      if (obs_a !== ex[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, obs_a, ex[i]);
      end
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  task automatic test_long_recover();
    // PULSE_CYC=1, RECOV_CYC=15: one-cycle pin pulse, CLK_EN low 16 cycles
    logic [6:0] exp_v;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      {RST, CLR_REQ, SET_REQ} = (i == 0) ? 3'b001 : 3'b000;
      @(posedge CLK); #1;
      if (i == 0)       exp_v = 7'b0101100;
      else if (i < 16)  exp_v = 7'b1101000;
      else if (i == 16) exp_v = 7'b1110010;
      else              exp_v = 7'b1110000;
      n_checks++;
      if (obs_b !== exp_v) begin
        n_fail++;
        $display("FAIL long_recover[%0d]: got %b want %b", i, obs_b, exp_v);
      end
    end
    {RST, CLR_REQ, SET_REQ} = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge CLK); #1;
    test_reset();
    test_set();
    test_both();
    test_clr_then_set();
    test_three_strobes();
    test_rst_mid();
    test_back_to_back();
    test_long_recover();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dffrsnq_async_ctrl_seq.md
# dffrsnq_async_ctrl_seq

Synchronous sequencer directly upstream of the dffrsnq asynchronous set/reset flop bank. It converts single-cycle preset/clear strobes into registered, glitch-free, active-low SETN/RN pulses of guaranteed width. It then holds a recovery window before re-enabling the bank clock, so the flops' removal and recovery timing is met by construction. SETN and RN are never low at the same time.

## Interface
- PULSE_CYC, 2, cycles SETN/RN is held low (1 to 2^CNT_W-1)
- RECOV_CYC, 2, cycles between pin release and CLK_EN reassertion (1 to 2^CNT_W-1)
- CNT_W, 4, width of the internal down-counter
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous reset, active-high
- SET_REQ  input  1  single-cycle strobe: preset bank to 1
- CLR_REQ  input  1  single-cycle strobe: clear bank to 0
- SETN  output  1  to flop SETN, active-low, registered
- RN  output  1  to flop RN, active-low, registered
- CLK_EN  output  1  bank clock-gate enable, registered
- BUSY  output  1  operation in progress
- REQ_ACK  output  1  one-cycle pulse, request captured
- DONE  output  1  one-cycle pulse, operation complete
- DROP  output  1  one-cycle pulse, request discarded

## Operation
- States: IDLE, ASSERT, RECOVER. The counter is loaded with PULSE_CYC-1 or RECOV_CYC-1 on entry and counts down to 0.
- IDLE: a strobe is sampled at edge E. On CLR_REQ, RN goes low. On SET_REQ alone, SETN goes low. In both cases CLK_EN=0, BUSY=1, REQ_ACK=1 and the state moves to ASSERT.
- If both strobes arrive in the same cycle, CLR wins. SET is discarded and DROP=1 in the same cycle as REQ_ACK.
- ASSERT: the active pin is held low. When the counter reaches 0, the pin is released and the state moves to RECOVER.
- RECOVER: SETN=RN=1 and CLK_EN=0. When the counter reaches 0, the state moves to IDLE with CLK_EN=1, BUSY=0 and DONE=1.
- A strobe arriving while BUSY: behaviour is defined under Configuration.
- Strobes are edge-agnostic level samples. A strobe held for N cycles counts as N requests.
- Reset values: SETN=1, RN=1, CLK_EN=1, BUSY=0, REQ_ACK=0, DONE=0, DROP=0, state IDLE, counter 0, queue empty.
- RST asserted mid-operation: the next edge forces the reset values. A low pin is released immediately and no DONE is issued. RST takes priority over any strobe in the same cycle.

## Timing
- Accept at edge E. The pin is low for exactly PULSE_CYC cycles (after E through E+PULSE_CYC).
- Pin high, CLK_EN low for exactly RECOV_CYC cycles.
- CLK_EN and DONE rise after edge E+PULSE_CYC+RECOV_CYC. BUSY is high for PULSE_CYC+RECOV_CYC cycles.
- A strobe sampled in the DONE cycle is accepted back-to-back.
- All outputs come straight from flops, so no combinational path runs from inputs to outputs.
- SETN and RN are never simultaneously 0, in any cycle, including across reset.

## Configuration
- DFFRSNQ_SEQ_QUEUE_EN defined: one pending-request slot.
  - A strobe while BUSY with the slot empty is stored, and REQ_ACK pulses.
  - A strobe while the slot is full produces DROP.
  - At the end of RECOVER, a pending request launches directly into ASSERT: CLK_EN stays 0, BUSY stays 1, and DONE still pulses for the finished operation.
  - Clear priority applies within the slot: a CLR overwrites a pending SET, and DROP pulses.
- Macro undefined: any strobe while BUSY produces DROP, no REQ_ACK, and no state change.

## Structure
- Package dffrsnq_seq_pkg holds:
  - the state enum (ST_IDLE, ST_ASSERT, ST_RECOVER);
  - the op enum (OP_NONE, OP_SET, OP_CLR);
  - the default PULSE_CYC, RECOV_CYC and CNT_W constants.
- One sub-module, dffrsnq_seq_timer: a loadable CNT_W-bit down-counter with a zero flag, instanced once.

## Test plan
- RST, then SET_REQ for 1 cycle (PULSE_CYC=2, RECOV_CYC=2) -> REQ_ACK at +1; SETN=0 for 2 cycles; CLK_EN=0 for 4 cycles; DONE and CLK_EN=1 at +5; RN constant 1.
- SET_REQ and CLR_REQ in the same cycle -> RN low for 2 cycles, SETN stays 1, DROP=1 alongside REQ_ACK.
- CLR_REQ, then SET_REQ 2 cycles later:
  - Queue off -> DROP, a single operation only.
  - Queue on -> REQ_ACK, the SET launches the cycle after RECOVER ends, CLK_EN stays 0 throughout, two DONE pulses.
- Queue on, three strobes during one BUSY window -> first launches, second queued, third DROP.
- RST asserted during ASSERT of a CLR -> next cycle RN=1, CLK_EN=1, BUSY=0, no DONE; a subsequent SET_REQ behaves as after cold reset.
- PULSE_CYC=1, RECOV_CYC=15 -> 1-cycle pin pulse, CLK_EN low exactly 16 cycles, no counter wrap.
